// File: rtl/alg1_div.sv
// Sequential unsigned divider by repeated subtraction: one subtract-and-count step per clock.
// Handshake: start is sampled only while busy=0; done/div_zero are levels that hold until the next accept or reset.
module alg1_div #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] aIn,
  input  logic [size-1:0] bIn,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [1:0]      o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [size-1:0] r_rem;
  logic [size-1:0] r_q;
  logic [size-1:0] r_dvs;
  logic [size-1:0] r_quotient;
  logic [size-1:0] r_remainder;
  logic            r_busy;
  logic            r_done;
  logic            r_div_zero;

  logic            w_ge;
  logic [size-1:0] w_rem_sub;
  logic [size-1:0] w_q_inc;
  logic            w_accept;
  logic            w_b_zero;

  assign w_ge      = (r_rem >= r_dvs);
  assign w_rem_sub = r_rem - r_dvs;
  assign w_q_inc   = r_q + {{(size-1){1'b0}}, 1'b1};
  assign w_accept  = start && (r_state != S_RUN);
  assign w_b_zero  = (bIn == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_b_zero) begin
              // Divide-by-zero completes immediately without entering RUN.
              r_state     <= S_DONE;
              r_quotient  <= '1;
              r_remainder <= aIn;
              r_done      <= 1'b1;
              r_div_zero  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state    <= S_RUN;
              r_rem      <= aIn;
              r_q        <= '0;
              r_dvs      <= bIn;
              r_done     <= 1'b0;
              r_div_zero <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_ge) begin
            r_rem <= w_rem_sub;
            r_q   <= w_q_inc;
          end else begin
            r_quotient  <= r_q;
            r_remainder <= r_rem;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign o_state   = r_state;

endmodule

// File: tb/tb_alg1_div.sv
// Directed bench for alg1_div: a 32-bit instance for the main scenarios, an 8-bit instance for corner runs.
module tb_alg1_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32;
  logic [31:0] a32, b32, q32, r32;
  logic        busy32, done32, dz32;
  logic [1:0]  st32;
  logic        start8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dz8;
  logic [1:0]  st8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alg1_div #(.size(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .aIn(a32), .bIn(b32),
    .quotient(q32), .remainder(r32), .busy(busy32), .done(done32),
    .div_zero(dz32), .o_state(st32)
  );

  alg1_div #(.size(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .aIn(a8), .bIn(b8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8),
    .div_zero(dz8), .o_state(st8)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Driver: pulse start for one edge, then count edges after accept until done (bounded).
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input int limit,
                      output int lat, output int bcnt);
    @(negedge clk);
    a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    bcnt = busy32 ? 1 : 0;
    while (!done32 && lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (busy32) bcnt++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int limit,
                     output int lat, output int bcnt);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start32 = 1'b1; a32 = 32'd5; b32 = 32'd1;
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({q32, r32} !== 64'd0) begin errors++; $display("FAIL reset_qr32: got q=%0d r=%0d expected 0 0", q32, r32); end
    checks++; if ({busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL reset_flags32: got %b expected 000", {busy32, done32, dz32}); end
    checks++; if (st32 !== 2'd0) begin errors++; $display("FAIL reset_state32: got %0d expected 0", st32); end
    checks++; if ({q8, r8, busy8, done8, dz8, st8} !== 21'd0) begin errors++; $display("FAIL reset_all8: got %h expected 0", {q8, r8, busy8, done8, dz8, st8}); end
    @(negedge clk);
    reset = 1'b0; start32 = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy32, done32, st32} !== 4'd0) begin errors++; $display("FAIL reset_idle_hold: got %b expected 0000", {busy32, done32, st32}); end
  endtask

  task automatic test_basic;
    int lat, bcnt;
    op32(32'd100, 32'd7, 1000, lat, bcnt);
    checks++; if (bcnt !== 15) begin errors++; $display("FAIL basic_busy_edges: got %0d expected 15", bcnt); end
    checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d expected 15", lat); end
    checks++; if (done32 !== 1'b1 || dz32 !== 1'b0) begin errors++; $display("FAIL basic_flags: got done=%b dz=%b expected 1 0", done32, dz32); end
    checks++; if (q32 !== 32'd14) begin errors++; $display("FAIL basic_q: got %0d expected 14", q32); end
    checks++; if (r32 !== 32'd2) begin errors++; $display("FAIL basic_r: got %0d expected 2", r32); end
    checks++; if (st32 !== 2'd2) begin errors++; $display("FAIL basic_state: got %0d expected 2", st32); end
  endtask

  task automatic test_small;
    int lat, bcnt;
    op32(32'd5, 32'd9, 1000, lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL small_lat_5_9: got %0d expected 1", lat); end
    checks++; if (q32 !== 32'd0 || r32 !== 32'd5) begin errors++; $display("FAIL small_qr_5_9: got q=%0d r=%0d expected 0 5", q32, r32); end
    op32(32'd9, 32'd9, 1000, lat, bcnt);
    checks++; if (lat !== 2) begin errors++; $display("FAIL small_lat_9_9: got %0d expected 2", lat); end
    checks++; if (q32 !== 32'd1 || r32 !== 32'd0) begin errors++; $display("FAIL small_qr_9_9: got q=%0d r=%0d expected 1 0", q32, r32); end
  endtask

  task automatic test_div_zero;
    int lat, bcnt;
    op32(32'd42, 32'd0, 1000, lat, bcnt);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", lat); end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL dz_busy: got %0d busy samples expected 0", bcnt); end
    checks++; if (done32 !== 1'b1 || dz32 !== 1'b1) begin errors++; $display("FAIL dz_flags: got done=%b dz=%b expected 1 1", done32, dz32); end
    checks++; if (q32 !== 32'hFFFF_FFFF || r32 !== 32'd42) begin errors++; $display("FAIL dz_qr: got q=%h r=%0d expected ffffffff 42", q32, r32); end
    op32(32'd10, 32'd3, 1000, lat, bcnt);
    checks++; if (dz32 !== 1'b0 || done32 !== 1'b1) begin errors++; $display("FAIL dz_clear: got dz=%b done=%b expected 0 1", dz32, done32); end
    checks++; if (q32 !== 32'd3 || r32 !== 32'd1 || lat !== 4) begin errors++; $display("FAIL dz_next_op: got q=%0d r=%0d lat=%0d expected 3 1 4", q32, r32, lat); end
  endtask

  task automatic test_ignore_and_reset;
    int lat, bcnt;
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a32 = 32'd8; b32 = 32'd2; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    checks++; if (busy32 !== 1'b1 || done32 !== 1'b0) begin errors++; $display("FAIL ignore_busy: got busy=%b done=%b expected 1 0", busy32, done32); end
    lat = 3;
    while (!done32 && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (q32 !== 32'd14 || r32 !== 32'd2 || lat !== 15) begin errors++; $display("FAIL ignore_result: got q=%0d r=%0d lat=%0d expected 14 2 15", q32, r32, lat); end

    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({q32, r32} !== 64'd0 || {busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL midrun_reset_out: got q=%0d r=%0d flags=%b expected 0 0 000", q32, r32, {busy32, done32, dz32}); end
    checks++; if (st32 !== 2'd0) begin errors++; $display("FAIL midrun_reset_state: got %0d expected 0", st32); end
    op32(32'd8, 32'd2, 1000, lat, bcnt);
    checks++; if (q32 !== 32'd4 || r32 !== 32'd0 || lat !== 5) begin errors++; $display("FAIL after_reset_op: got q=%0d r=%0d lat=%0d expected 4 0 5", q32, r32, lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a32 = 32'd20; b32 = 32'd4; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd7; b32 = 32'd2;
    lat = 0;
    while (!done32 && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (q32 !== 32'd5 || r32 !== 32'd0 || lat !== 6) begin errors++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d expected 5 0 6", q32, r32, lat); end
    @(posedge clk); #1;
    start32 = 1'b0;
    checks++; if (done32 !== 1'b0 || busy32 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done32, busy32); end
    lat = 0;
    while (!done32 && lat < 1000) begin @(posedge clk); #1; lat++; end
    checks++; if (q32 !== 32'd3 || r32 !== 32'd1 || lat !== 4) begin errors++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d expected 3 1 4", q32, r32, lat); end
  endtask

  task automatic test_size8;
    logic [7:0] va [7] = '{8'd255, 8'd200, 8'd0, 8'd3,   8'd255, 8'd128, 8'd77};
    logic [7:0] vb [7] = '{8'd1,   8'd13,  8'd5, 8'd250, 8'd255, 8'd16,  8'd0};
    logic [7:0] vq [7] = '{8'd255, 8'd15,  8'd0, 8'd0,   8'd1,   8'd8,   8'hFF};
    logic [7:0] vr [7] = '{8'd0,   8'd5,   8'd0, 8'd3,   8'd0,   8'd0,   8'd77};
    int lat, bcnt, exp_lat;
    for (int i = 0; i < 7; i++) begin
      op8(va[i], vb[i], 400, lat, bcnt);
      exp_lat = (vb[i] == 8'd0) ? 0 : int'(vq[i]) + 1;
      checks++; if (q8 !== vq[i] || r8 !== vr[i]) begin errors++; $display("FAIL s8_qr[%0d]: got q=%0d r=%0d expected %0d %0d", i, q8, r8, vq[i], vr[i]); end
      checks++; if (lat !== exp_lat || done8 !== 1'b1) begin errors++; $display("FAIL s8_latency[%0d]: got %0d done=%b expected %0d 1", i, lat, done8, exp_lat); end
      checks++; if (dz8 !== (vb[i] == 8'd0)) begin errors++; $display("FAIL s8_dz[%0d]: got %b expected %b", i, dz8, (vb[i] == 8'd0)); end
      if (vb[i] != 8'd0) begin
        checks++;
        if ((int'(q8) * int'(vb[i]) + int'(r8)) !== int'(va[i]) || r8 >= vb[i]) begin
          errors++; $display("FAIL s8_invariant[%0d]: got q=%0d r=%0d for %0d/%0d", i, q8, r8, va[i], vb[i]);
        end
      end
      if (i == 0) begin
        checks++; if (bcnt !== 256) begin errors++; $display("FAIL s8_worst_busy: got %0d expected 256", bcnt); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; start32 = 1'b0; start8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_small();
    test_div_zero();
    test_ignore_and_reset();
    test_back_to_back();
    test_size8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
